// File: rtl/apb_to_axil_bridge.sv
// apb_to_axil_bridge: APB slave to AXI4-Lite master, exactly one AXI transaction per APB transfer
module apb_to_axil_bridge #(
  parameter int AW_APB = 32,
  parameter int DW_APB = 64,
  parameter int AW_AXI = 32,
  parameter int DW_AXI = 64
) (
  input  logic                axi_clk,
  input  logic                sys_rst,
  input  logic [AW_APB-1:0]   s_apb_paddr,
  input  logic                s_apb_psel,
  input  logic                s_apb_penable,
  input  logic                s_apb_pwrite,
  input  logic [2:0]          s_apb_pprot,
  input  logic [DW_APB/8-1:0] s_apb_pstrb,
  input  logic [DW_APB-1:0]   s_apb_pwdata,
  output logic                s_apb_pready,
  output logic [DW_APB-1:0]   s_apb_prdata,
  output logic                s_apb_pslverr,
  output logic [AW_AXI-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DW_AXI-1:0]   m_axi_wdata,
  output logic [DW_AXI/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [AW_AXI-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DW_AXI-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DONE, WAIT_END} state_t;
  state_t state, state_nxt;
  logic access, aw_done, w_done;
  logic [AW_AXI-1:0] addr;
  logic [2:0] prot;
  logic unused_resp;
  assign access = s_apb_psel & s_apb_penable;
  assign aw_done = !m_axi_awvalid | m_axi_awready;
  assign w_done = !m_axi_wvalid | m_axi_wready;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_awprot = prot;
  assign m_axi_arprot = prot;
  assign m_axi_bready = state == WR_RESP;
  assign m_axi_rready = state == RD_RESP;
  assign s_apb_pready = state == DONE;
  assign unused_resp = m_axi_bresp[0] ^ m_axi_rresp[0];
  always_ff @(posedge axi_clk) state <= sys_rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         state_nxt = access ? (s_apb_pwrite ? WR_ADDR_DATA : RD_ADDR) : IDLE;
      WR_ADDR_DATA: state_nxt = aw_done & w_done ? WR_RESP : WR_ADDR_DATA;
      WR_RESP:      state_nxt = m_axi_bvalid ? DONE : WR_RESP;
      RD_ADDR:      state_nxt = m_axi_arready ? RD_RESP : RD_ADDR;
      RD_RESP:      state_nxt = m_axi_rvalid ? DONE : RD_RESP;
      DONE:         state_nxt = WAIT_END;
      WAIT_END:     state_nxt = access ? WAIT_END : IDLE;
      default:      state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk) begin
    if (sys_rst) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_arvalid <= 1'b0;
      addr <= '0;
      prot <= '0;
      m_axi_wdata <= '0;
      m_axi_wstrb <= '0;
      s_apb_prdata <= '0;
      s_apb_pslverr <= 1'b0;
    end else begin
      if (state == IDLE && access) begin
        addr <= AW_AXI'(s_apb_paddr);
        prot <= s_apb_pprot;
        m_axi_wdata <= DW_AXI'(s_apb_pwdata);
        m_axi_wstrb <= (DW_AXI/8)'(s_apb_pstrb);
        m_axi_awvalid <= s_apb_pwrite;
        m_axi_wvalid <= s_apb_pwrite;
        m_axi_arvalid <= !s_apb_pwrite;
      end
      if (m_axi_awvalid & m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid & m_axi_wready) m_axi_wvalid <= 1'b0;
      if (m_axi_arvalid & m_axi_arready) m_axi_arvalid <= 1'b0;
      if (state == WR_RESP && m_axi_bvalid) s_apb_pslverr <= m_axi_bresp[1];
      if (state == RD_RESP && m_axi_rvalid) begin
        s_apb_prdata <= DW_APB'(m_axi_rdata);
        s_apb_pslverr <= m_axi_rresp[1];
      end
    end
  end
endmodule

// File: tb/tb_apb_to_axil_bridge.sv
// tb_apb_to_axil_bridge: directed APB traffic against a configurable-latency AXI-Lite memory slave
module tb_apb_to_axil_bridge;
  logic axi_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [31:0] s_apb_paddr;
  logic s_apb_psel, s_apb_penable, s_apb_pwrite;
  logic [2:0] s_apb_pprot;
  logic [7:0] s_apb_pstrb;
  logic [63:0] s_apb_pwdata;
  logic s_apb_pready, s_apb_pslverr;
  logic [63:0] s_apb_prdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  int tests = 0;
  int fails = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_v = 2'b00, rresp_v = 2'b00;
  int aw_c, w_c, b_c, ar_c, r_c, aw_total, w_total, ar_total, stab_cnt;
  bit aw_got, w_got, ar_got, b_hs, r_hs;
  logic [31:0] awa, ara, awa_first, ara_first;
  logic [2:0] awp, arp;
  logic [63:0] wd, wd_first;
  logic [7:0] ws;
  logic [63:0] mem [16];
  logic [63:0] rd;
  bit err;
  int lat, a0, w0, r0, s0;

  always #5 axi_clk = ~axi_clk;

  apb_to_axil_bridge dut (
    .axi_clk(axi_clk), .sys_rst(sys_rst),
    .s_apb_paddr(s_apb_paddr), .s_apb_psel(s_apb_psel), .s_apb_penable(s_apb_penable),
    .s_apb_pwrite(s_apb_pwrite), .s_apb_pprot(s_apb_pprot), .s_apb_pstrb(s_apb_pstrb),
    .s_apb_pwdata(s_apb_pwdata), .s_apb_pready(s_apb_pready), .s_apb_prdata(s_apb_prdata),
    .s_apb_pslverr(s_apb_pslverr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                     input logic [2:0] p, input int hold, output logic [63:0] rdo, output bit erro,
                     output int lato);
    bit seen = 0;
    @(negedge axi_clk);
    s_apb_psel = 1; s_apb_penable = 0; s_apb_pwrite = wr;
    s_apb_paddr = a; s_apb_pwdata = d; s_apb_pstrb = s; s_apb_pprot = p;
    @(negedge axi_clk);
    s_apb_penable = 1;
    lato = 0;
    while (!seen && lato < 100) begin
      @(negedge axi_clk);
      lato++;
      seen = s_apb_pready;
    end
    chk("pready_seen", seen, 1);
    rdo = s_apb_prdata;
    erro = s_apb_pslverr;
    @(negedge axi_clk);
    chk("pready_one_cycle", s_apb_pready, 0);
    repeat (hold) @(negedge axi_clk);
    s_apb_psel = 0; s_apb_penable = 0;
    @(negedge axi_clk);
  endtask

  initial begin
    {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
    m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    {aw_c, w_c, b_c, ar_c, r_c, aw_total, w_total, ar_total, stab_cnt} = '0;
    {aw_got, w_got, ar_got, b_hs, r_hs} = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    forever begin
      @(negedge axi_clk);
      if (sys_rst) begin
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        {aw_got, w_got, ar_got, b_hs, r_hs} = '0;
      end else begin
        if (b_hs) begin
          m_axi_bvalid = 0; {b_hs, aw_got, w_got} = '0; {aw_c, w_c, b_c} = '0;
        end else if (aw_got && w_got) begin
          if (b_c >= b_dly) begin
            m_axi_bvalid = 1; m_axi_bresp = bresp_v;
            if (m_axi_bready) begin
              b_hs = 1;
              for (int b = 0; b < 8; b++) if (ws[b]) mem[awa[6:3]][b*8 +: 8] = wd[b*8 +: 8];
            end
          end else b_c++;
        end
        if (r_hs) begin
          m_axi_rvalid = 0; {r_hs, ar_got} = '0; {ar_c, r_c} = '0;
        end else if (ar_got) begin
          if (r_c >= r_dly) begin
            m_axi_rvalid = 1; m_axi_rresp = rresp_v; m_axi_rdata = mem[ara[6:3]];
            if (m_axi_rready) r_hs = 1;
          end else r_c++;
        end
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        if (!aw_got && aw_c > 0 && (!m_axi_awvalid || m_axi_awaddr !== awa_first)) stab_cnt++;
        if (!w_got && w_c > 0 && (!m_axi_wvalid || m_axi_wdata !== wd_first)) stab_cnt++;
        if (!ar_got && ar_c > 0 && (!m_axi_arvalid || m_axi_araddr !== ara_first)) stab_cnt++;
        if (m_axi_awvalid && !aw_got) begin
          if (aw_c == 0) awa_first = m_axi_awaddr;
          if (aw_c >= aw_dly) begin
            m_axi_awready = 1; aw_got = 1; awa = m_axi_awaddr; awp = m_axi_awprot; aw_total++;
          end else aw_c++;
        end
        if (m_axi_wvalid && !w_got) begin
          if (w_c == 0) wd_first = m_axi_wdata;
          if (w_c >= w_dly) begin
            m_axi_wready = 1; w_got = 1; wd = m_axi_wdata; ws = m_axi_wstrb; w_total++;
          end else w_c++;
        end
        if (m_axi_arvalid && !ar_got) begin
          if (ar_c == 0) ara_first = m_axi_araddr;
          if (ar_c >= ar_dly) begin
            m_axi_arready = 1; ar_got = 1; ara = m_axi_araddr; arp = m_axi_arprot; ar_total++;
          end else ar_c++;
        end
      end
    end
  end

  initial begin
    s_apb_psel = 0; s_apb_penable = 0; s_apb_pwrite = 0;
    s_apb_paddr = 0; s_apb_pwdata = 0; s_apb_pstrb = 0; s_apb_pprot = 0;
    repeat (3) @(negedge axi_clk);
    chk("reset_ctrl", {s_apb_pready, s_apb_pslverr, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 0);
    chk("reset_prdata", s_apb_prdata, 0);
    chk("reset_addr", {m_axi_awaddr, m_axi_araddr}, 0);
    sys_rst = 0;
    for (int i = 0; i < 16; i++) begin
      a0 = aw_total; w0 = w_total;
      apb(1, i * 8, 64'h1111_0000_0000_0000 + i, 8'hAF, 3'b000, 0, rd, err, lat);
      chk("wr_latency", lat, 3);
      chk("wr_pslverr", err, 0);
      chk("wr_one_aw_w", {aw_total - a0, w_total - w0}, {32'd1, 32'd1});
      chk("wr_awaddr", awa, i * 8);
      chk("wr_wstrb", ws, 8'hAF);
      chk("wr_wdata", wd, 64'h1111_0000_0000_0000 + i);
    end
    for (int i = 0; i < 16; i++) begin
      r0 = ar_total;
      apb(0, i * 8, 0, 0, 3'b000, 0, rd, err, lat);
      chk("rd_latency", lat, 3);
      chk("rd_pslverr", err, 0);
      chk("rd_one_ar", ar_total - r0, 1);
      chk("rd_araddr", ara, i * 8);
      chk("rd_prdata", rd, 64'h1100_0000_0000_0000 + i);
    end
    apb(1, 32'h0, 64'hDEAD_BEEF_0000_0001, 8'hFF, 3'b000, 0, rd, err, lat);
    chk("prdata_kept_over_write", s_apb_prdata, 64'h1100_0000_0000_000F);
    apb(0, 32'h0, 0, 0, 3'b000, 0, rd, err, lat);
    chk("rd_full_strobe", rd, 64'hDEAD_BEEF_0000_0001);
    aw_dly = 3; w_dly = 1; b_dly = 5;
    a0 = aw_total; s0 = stab_cnt;
    apb(1, 32'h10, 64'hA5A5_5A5A_0123_4567, 8'hFF, 3'b101, 0, rd, err, lat);
    chk("bp_wr_latency", lat, 11);
    chk("bp_wr_stable", stab_cnt - s0, 0);
    chk("bp_wr_one_aw", aw_total - a0, 1);
    chk("bp_wr_awprot", awp, 3'b101);
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 2; r_dly = 3;
    r0 = ar_total; s0 = stab_cnt;
    apb(0, 32'h10, 0, 0, 3'b011, 0, rd, err, lat);
    chk("bp_rd_latency", lat, 8);
    chk("bp_rd_stable", stab_cnt - s0, 0);
    chk("bp_rd_one_ar", ar_total - r0, 1);
    chk("bp_rd_arprot", arp, 3'b011);
    chk("bp_rd_prdata", rd, 64'hA5A5_5A5A_0123_4567);
    ar_dly = 0; r_dly = 0;
    a0 = aw_total;
    apb(1, 32'h18, 64'h77, 8'hFF, 3'b000, 2, rd, err, lat);
    chk("hold_one_aw", aw_total - a0, 1);
    apb(0, 32'h18, 0, 0, 3'b000, 0, rd, err, lat);
    chk("after_hold_latency", lat, 3);
    chk("after_hold_prdata", rd, 64'h77);
    bresp_v = 2'b10;
    apb(1, 32'h20, 64'h1, 8'hFF, 3'b000, 0, rd, err, lat);
    chk("bresp_err", err, 1);
    bresp_v = 2'b00; rresp_v = 2'b11;
    apb(0, 32'h20, 0, 0, 3'b000, 0, rd, err, lat);
    chk("rresp_err", err, 1);
    chk("rresp_prdata", rd, 64'h1);
    rresp_v = 2'b00;
    apb(0, 32'h20, 0, 0, 3'b000, 0, rd, err, lat);
    chk("okay_clears_err", err, 0);
    aw_dly = 10;
    @(negedge axi_clk);
    s_apb_psel = 1; s_apb_penable = 0; s_apb_pwrite = 1;
    s_apb_paddr = 32'h28; s_apb_pwdata = 64'h99; s_apb_pstrb = 8'hFF;
    @(negedge axi_clk);
    s_apb_penable = 1;
    @(negedge axi_clk);
    chk("pre_reset_awvalid", m_axi_awvalid, 1);
    sys_rst = 1; s_apb_psel = 0; s_apb_penable = 0;
    @(negedge axi_clk);
    chk("midrst_ctrl", {s_apb_pready, s_apb_pslverr, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                        m_axi_bready, m_axi_rready}, 0);
    chk("midrst_prdata", s_apb_prdata, 0);
    @(negedge axi_clk);
    sys_rst = 0; aw_dly = 0;
    apb(1, 32'h28, 64'h99, 8'hFF, 3'b000, 0, rd, err, lat);
    chk("post_rst_wr_latency", lat, 3);
    chk("post_rst_wr_err", err, 0);
    apb(0, 32'h28, 0, 0, 3'b000, 0, rd, err, lat);
    chk("post_rst_rd", rd, 64'h99);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
